// File: rtl/operand_pair_feeder.sv
// operand_pair_feeder: joins the A and B operand streams into pairs and buffers them in a
// DEPTH-entry FIFO. The head pair is presented on in0/in1 for the combine stage.
// Optional feature: define OPERAND_FEED_STATS_EN to add a saturating pop counter (pair_count).
module operand_pair_feeder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] in0,
    output logic [WIDTH-1:0] in1,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [AW:0]      level
`ifdef OPERAND_FEED_STATS_EN
    ,
    output logic [15:0]      pair_count
`endif
);

    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic               full, empty, push, pop;

    assign full       = (level_q == FullLevel);
    assign empty      = (level_q == '0);
    assign pair_valid = !empty;
    assign level      = level_q;

    // Join: each side is accepted only together with its partner, so neither ready looks at
    // its own valid and neither depends on pair_ready.
    assign a_ready = b_valid & !full & !flush;
    assign b_ready = a_valid & !full & !flush;
    assign push    = a_valid & b_valid & !full & !flush;
    assign pop     = pair_valid & pair_ready & !flush;

    // Head pair is read straight out of the array; stale contents show when empty.
    assign in0 = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
    assign in1 = mem_q[rd_ptr_q][WIDTH-1:0];

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Pair storage; cleared only by reset, flush leaves contents in place.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {a_data, b_data};
        end
    end

`ifdef OPERAND_FEED_STATS_EN
    logic [15:0] count_q;

    // Saturating pop counter; flush clears it even on a coincident pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (pop && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign pair_count = count_q;
`endif

endmodule

// File: tb/tb_operand_pair_feeder.sv
// Self-checking bench for operand_pair_feeder: directed scenarios plus random traffic, all
// checked against a queue-based model of the pair FIFO.
module tb_operand_pair_feeder;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_valid = 1'b0;
    logic             a_ready;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_valid = 1'b0;
    logic             b_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             pair_valid;
    logic             pair_ready = 1'b0;
    logic [AW:0]      level;
`ifdef OPERAND_FEED_STATS_EN
    logic [15:0]      pair_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pairs in arrival order, {a, b} per entry.
    logic [2*WIDTH-1:0] model_q[$];
    int                 exp_count = 0;

    operand_pair_feeder #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .in0       (in0),
        .in1       (in1),
        .pair_valid(pair_valid),
        .pair_ready(pair_ready),
        .level     (level)
`ifdef OPERAND_FEED_STATS_EN
        ,
        .pair_count(pair_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check readies, advance model.
    task automatic step(input logic av, input logic [WIDTH-1:0] ad, input logic bv,
                        input logic [WIDTH-1:0] bd, input logic pr, input logic fl);
        logic               full, push, pop;
        logic [2*WIDTH-1:0] head;
        @(negedge clock);
        check_eq("level", 32'(level), model_q.size());
        check_eq("pair_valid", 32'(pair_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            head = model_q[0];
            check_eq("in0", 32'(in0), 32'(head[2*WIDTH-1:WIDTH]));
            check_eq("in1", 32'(in1), 32'(head[WIDTH-1:0]));
        end
`ifdef OPERAND_FEED_STATS_EN
        check_eq("pair_count", 32'(pair_count), exp_count);
`endif
        a_valid    = av;
        a_data     = ad;
        b_valid    = bv;
        b_data     = bd;
        pair_ready = pr;
        flush      = fl;
        #1;
        full = (model_q.size() == DEPTH);
        check_eq("a_ready", 32'(a_ready), 32'(bv & !full & !fl));
        check_eq("b_ready", 32'(b_ready), 32'(av & !full & !fl));
        push = av & bv & !full & !fl;
        pop  = (model_q.size() != 0) & pr & !fl;
        if (fl) begin
            model_q.delete();
            exp_count = 0;
        end else begin
            if (pop) begin
                void'(model_q.pop_front());
                if (exp_count < 16'hFFFF) exp_count++;
            end
            if (push) model_q.push_back({ad, bd});
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pair_valid"}, 32'(pair_valid), 0);
        check_eq({tag, "_level"}, 32'(level), 0);
        check_eq({tag, "_in0"}, 32'(in0), 0);
        check_eq({tag, "_in1"}, 32'(in1), 0);
        check_eq({tag, "_a_ready"}, 32'(a_ready), 0);
        check_eq({tag, "_b_ready"}, 32'(b_ready), 0);
    endtask

    initial begin
        // Reset state at time zero.
        #2;
        check_reset_state("rst0");
        @(negedge clock);
        reset_n = 1'b1;

        // Join: A alone is never taken.
        for (int i = 0; i < 3; i++) step(1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        check_eq("join_in0", 32'(in0), 32'h5);
        check_eq("join_in1", 32'(in1), 32'hA);
        check_eq("join_level", 32'(level), 1);

        // Fill to full, hold (5,5), then a single pop lets it in.
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'h5, 1'b1, 4'h5, 1'b0, 1'b0);
        check_eq("full_level", 32'(level), DEPTH);
        step(1'b1, 4'h5, 1'b1, 4'h5, 1'b1, 1'b0);
        step(1'b1, 4'h5, 1'b1, 4'h5, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

        // Flush with push and pop requested in the same cycle.
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 7), 1'b1, 4'(i + 9), 1'b0, 1'b0);
        step(1'b1, 4'hE, 1'b1, 4'hD, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        check_eq("flush_level", 32'(level), 0);
        check_eq("flush_pair_valid", 32'(pair_valid), 0);

        // Back-to-back streaming across pointer wrap.
        for (int i = 0; i < 20; i++) step(1'b1, 4'(i), 1'b1, 4'(15 - i), 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset with pairs stored.
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 3), 1'b1, 4'(i + 6), 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        model_q.delete();
        exp_count = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 1), 1'b1, 4'(i + 2), 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
